// File: rtl/np_frame_scheduler.sv
// Frame scheduler feeding the neopixel driver pixel-write port from one of two pattern sources.
// Optional frame/overrun statistics outputs are enabled by defining NP_FRAME_STATS_EN.
module np_frame_scheduler #(
  parameter int unsigned NUM_LEDS  = 150,
  parameter int unsigned FRAME_DIV = 416667,
  parameter int unsigned WR_HOLD   = 4,
  parameter int unsigned DATA_TMO  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        src1_active,
  output logic        pix_req,
  output logic [15:0] pix_addr,
  output logic        pix_sel,
  input  logic        src0_valid,
  input  logic [23:0] src0_color,
  input  logic        src1_valid,
  input  logic [23:0] src1_color,
  output logic [23:0] color,
  output logic [15:0] address,
  output logic        color_clock,
  output logic        frame_start,
  output logic        busy,
  output logic        tmo_err
`ifdef NP_FRAME_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [7:0]  overrun_cnt
`endif
);

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned COLOR_W = 24;
  localparam int unsigned TMR_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned TMO_W   = (DATA_TMO > 1) ? $clog2(DATA_TMO + 1) : 1;
  localparam int unsigned HLD_W   = (WR_HOLD > 1) ? $clog2(WR_HOLD + 1) : 1;

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(FRAME_DIV - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(DATA_TMO - 1);
  localparam logic [HLD_W-1:0]  HLD_LAST  = HLD_W'(WR_HOLD - 1);
  localparam logic [ADDR_W-1:0] ADDR_TOP  = ADDR_W'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SETUP,
    S_STROBE,
    S_NEXT
  } state_t;

  state_t             r_state;
  logic [TMR_W-1:0]   r_timer;
  logic [TMO_W-1:0]   r_wait_cnt;
  logic [HLD_W-1:0]   r_hold_cnt;

  logic               w_tick;
  logic               w_start;
  logic               w_src_valid;
  logic [COLOR_W-1:0] w_src_color;
  logic               w_tmo;
  logic               w_hold_done;

  // Frame-rate timer; the tick is the cycle in which it wraps back to zero.
  assign w_tick = (r_timer == TMR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  assign w_start     = (r_state == S_IDLE) && w_tick && enable;
  assign w_src_valid = pix_sel ? src1_valid : src0_valid;
  assign w_src_color = pix_sel ? src1_color : src0_color;
  assign w_tmo       = (r_wait_cnt == TMO_LAST);
  assign w_hold_done = (r_hold_cnt == HLD_LAST);

  // Per-pixel sequencer; every driver-facing output is a register written here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_hold_cnt  <= '0;
      pix_req     <= 1'b0;
      pix_addr    <= '0;
      pix_sel     <= 1'b0;
      color       <= '0;
      address     <= '0;
      color_clock <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      tmo_err     <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      pix_req     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            frame_start <= 1'b1;
            pix_sel     <= src1_active;
            pix_addr    <= ADDR_TOP;
            busy        <= 1'b1;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          pix_req    <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // Only the source owning this frame is watched; a timeout writes black.
          if (w_src_valid) begin
            color      <= w_src_color;
            address    <= pix_addr;
            r_hold_cnt <= '0;
            r_state    <= S_SETUP;
          end else if (w_tmo) begin
            color      <= '0;
            address    <= pix_addr;
            tmo_err    <= 1'b1;
            r_hold_cnt <= '0;
            r_state    <= S_SETUP;
          end else begin
            r_wait_cnt <= r_wait_cnt + TMO_W'(1);
          end
        end
        S_SETUP: begin
          if (w_hold_done) begin
            r_hold_cnt  <= '0;
            color_clock <= 1'b1;
            r_state     <= S_STROBE;
          end else begin
            r_hold_cnt <= r_hold_cnt + HLD_W'(1);
          end
        end
        S_STROBE: begin
          if (w_hold_done) begin
            r_hold_cnt  <= '0;
            color_clock <= 1'b0;
            r_state     <= S_NEXT;
          end else begin
            r_hold_cnt <= r_hold_cnt + HLD_W'(1);
          end
        end
        S_NEXT: begin
          if (pix_addr == '0) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            pix_addr <= pix_addr - ADDR_W'(1);
            r_state  <= S_REQ;
          end
        end
        default: begin
          color_clock <= 1'b0;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef NP_FRAME_STATS_EN
  logic w_drop;

  // A tick that arrives while a frame is in flight is lost, not queued.
  assign w_drop = (r_state != S_IDLE) && w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      overrun_cnt <= '0;
    end else begin
      if (w_start) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (w_drop && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
